// File: rtl/idu_pipe_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the pipelined instruction decoder.
// The MulDiv_En signal exists only when IDP_MULDIV_EN is defined.
interface idu_pipe_decoder_if #(
  parameter int unsigned INSTR_W = 32
);
  logic [INSTR_W-1:0] IDP_Instr_InBUS;
  logic               IDP_Instr_Valid_In;
  logic               IDP_Instr_Ready_Out;
  logic               IDP_Ctrl_Valid_Out;
  logic               IDP_Ctrl_Ready_In;
  logic [4:0]         IDP_Rd_OutBUS;
  logic [4:0]         IDP_Rs1_OutBUS;
  logic [4:0]         IDP_Rs2_OutBUS;
  logic [2:0]         IDP_Funct3_OutBUS;
  logic               IDP_Not_Branch_Jump_Op;
  logic               IDP_RegFile_Write;
  logic               IDP_Bru_En;
  logic               IDP_Alu_Select_Immediate_Mux;
  logic               IDP_Lsu_En;
  logic [1:0]         IDP_RegFile_Mux_OutBUS;
  logic [1:0]         IDP_AluOp_OutBUS;
  logic               IDP_Illegal_Out;
`ifdef IDP_MULDIV_EN
  logic               IDP_MulDiv_En;
`endif

  // Decoder side.
  modport slave (
    input  IDP_Instr_InBUS, IDP_Instr_Valid_In, IDP_Ctrl_Ready_In,
    output IDP_Instr_Ready_Out, IDP_Ctrl_Valid_Out,
    output IDP_Rd_OutBUS, IDP_Rs1_OutBUS, IDP_Rs2_OutBUS, IDP_Funct3_OutBUS,
    output IDP_Not_Branch_Jump_Op, IDP_RegFile_Write, IDP_Bru_En,
    output IDP_Alu_Select_Immediate_Mux, IDP_Lsu_En,
    output IDP_RegFile_Mux_OutBUS, IDP_AluOp_OutBUS, IDP_Illegal_Out
`ifdef IDP_MULDIV_EN
    , output IDP_MulDiv_En
`endif
  );

  // Fetch/execute side.
  modport master (
    output IDP_Instr_InBUS, IDP_Instr_Valid_In, IDP_Ctrl_Ready_In,
    input  IDP_Instr_Ready_Out, IDP_Ctrl_Valid_Out,
    input  IDP_Rd_OutBUS, IDP_Rs1_OutBUS, IDP_Rs2_OutBUS, IDP_Funct3_OutBUS,
    input  IDP_Not_Branch_Jump_Op, IDP_RegFile_Write, IDP_Bru_En,
    input  IDP_Alu_Select_Immediate_Mux, IDP_Lsu_En,
    input  IDP_RegFile_Mux_OutBUS, IDP_AluOp_OutBUS, IDP_Illegal_Out
`ifdef IDP_MULDIV_EN
    , input IDP_MulDiv_En
`endif
  );
endinterface

// File: rtl/idu_pipe_decoder.sv
// Registered, handshaked instruction decoder with an LSU wait FSM, timeout, flush and
// illegal-opcode detection. Define IDP_MULDIV_EN to decode M-extension R-type ops.
module idu_pipe_decoder #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned LSU_TIMEOUT = 15
) (
  input  logic              IDP_CLOCK_50,
  input  logic              IDP_RESET_InHigh,
  input  logic              IDP_Flush_In,
  input  logic              IDP_Lsu_Done_In,
  output logic              IDP_Lsu_Timeout_Out,
  idu_pipe_decoder_if.slave idp
);

  localparam int unsigned     CntW    = $clog2(LSU_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LSU_TIMEOUT - 1);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  typedef enum logic [0:0] {StRun, StLsuWait} state_e;

  typedef struct packed {
    logic       not_brj;
    logic       wr;
    logic       bru;
    logic       imm;
    logic       lsu;
    logic       illegal;
`ifdef IDP_MULDIV_EN
    logic       muldiv;
`endif
    logic [1:0] mux;
    logic [1:0] aluop;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } bundle_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  bundle_t         bundle_q, bundle_d;
  bundle_t         dec;
  bundle_t         out_b;
  logic [6:0]      op;
  logic [6:0]      funct7;
  logic            instr_ready;
  logic            accept;
  logic            xfer;
  logic            timeout;

  assign op     = idp.IDP_Instr_InBUS[6:0];
  assign funct7 = idp.IDP_Instr_InBUS[31:25];

  // Opcode decode of the incoming instruction; captured into bundle_q on accept.
  always_comb begin
    dec        = '0;
    dec.rd     = idp.IDP_Instr_InBUS[11:7];
    dec.funct3 = idp.IDP_Instr_InBUS[14:12];
    dec.rs1    = idp.IDP_Instr_InBUS[19:15];
    dec.rs2    = idp.IDP_Instr_InBUS[24:20];
    case (op)
      OpLui, OpAuipc: begin
        dec.mux   = {~op[5], 1'b0};
        dec.wr    = 1'b1;
        dec.aluop = 2'b11;
        dec.imm   = 1'b1;
      end
      OpJal, OpJalr: begin
        dec.not_brj = 1'b1;
        dec.mux     = 2'b11;
        dec.wr      = 1'b1;
        dec.aluop   = 2'b10;
        dec.imm     = 1'b1;
      end
      OpBranch: begin
        dec.bru = 1'b1;
      end
      OpLoad, OpStore: begin
        dec.mux   = 2'b01;
        dec.wr    = ~op[5];
        dec.aluop = 2'b01;
        dec.imm   = 1'b1;
        dec.lsu   = 1'b1;
      end
      OpImm: begin
        dec.wr  = 1'b1;
        dec.imm = ~op[5];
      end
      OpReg: begin
        if (funct7 == F7MulDiv) begin
`ifdef IDP_MULDIV_EN
          dec.wr     = 1'b1;
          dec.muldiv = 1'b1;
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.wr  = 1'b1;
          dec.imm = ~op[5];
        end
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Flush and reset both block acceptance in the cycle they are asserted.
  assign instr_ready = (state_q == StRun) && (!valid_q || idp.IDP_Ctrl_Ready_In) &&
                       !IDP_Flush_In && !IDP_RESET_InHigh;
  assign accept      = idp.IDP_Instr_Valid_In && instr_ready;
  assign xfer        = valid_q && idp.IDP_Ctrl_Ready_In;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (IDP_Flush_In) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (IDP_Flush_In || IDP_RESET_InHigh) begin
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (xfer && bundle_q.lsu) begin
            state_d = StLsuWait;
            cnt_d   = '0;
          end
        end
        StLsuWait: begin
          if (IDP_Lsu_Done_In) begin
            state_d = StRun;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StRun;
            cnt_d   = '0;
            timeout = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge IDP_CLOCK_50) begin
    if (IDP_RESET_InHigh) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  // Every bundle output reads as zero while nothing valid is held.
  assign out_b = valid_q ? bundle_q : '0;

  assign IDP_Lsu_Timeout_Out              = timeout;
  assign idp.IDP_Instr_Ready_Out          = instr_ready;
  assign idp.IDP_Ctrl_Valid_Out           = valid_q;
  assign idp.IDP_Rd_OutBUS                = out_b.rd;
  assign idp.IDP_Rs1_OutBUS               = out_b.rs1;
  assign idp.IDP_Rs2_OutBUS               = out_b.rs2;
  assign idp.IDP_Funct3_OutBUS            = out_b.funct3;
  assign idp.IDP_Not_Branch_Jump_Op       = out_b.not_brj;
  assign idp.IDP_RegFile_Write            = out_b.wr;
  assign idp.IDP_Bru_En                   = out_b.bru;
  assign idp.IDP_Alu_Select_Immediate_Mux = out_b.imm;
  assign idp.IDP_Lsu_En                   = out_b.lsu;
  assign idp.IDP_RegFile_Mux_OutBUS       = out_b.mux;
  assign idp.IDP_AluOp_OutBUS             = out_b.aluop;
  assign idp.IDP_Illegal_Out              = out_b.illegal;
`ifdef IDP_MULDIV_EN
  assign idp.IDP_MulDiv_En                = out_b.muldiv;
`endif

endmodule

// File: tb/tb_idu_pipe_decoder.sv
// Self-checking bench for idu_pipe_decoder: directed scenarios plus a randomized stream
// checked against a decode-table model and an in-order scoreboard.
module tb_idu_pipe_decoder;

  localparam int unsigned T = 15;

  localparam logic [31:0] InsAddi = 32'h0050_0093;
  localparam logic [31:0] InsAdd  = 32'h0020_81B3;
  localparam logic [31:0] InsLw   = 32'h0000_A103;
  localparam logic [31:0] InsSw   = 32'h0020_A223;
  localparam logic [31:0] InsJal  = 32'h0080_00EF;
  localparam logic [31:0] InsMul  = 32'h0220_81B3;
  localparam logic [31:0] InsBad  = 32'h0000_007F;
  localparam logic [31:0] InsLow  = 32'h0000_0012;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic done = 1'b0;
  logic tmo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  idu_pipe_decoder_if #(.INSTR_W(32)) bus ();

  idu_pipe_decoder #(
    .INSTR_W    (32),
    .LSU_TIMEOUT(T)
  ) dut (
    .IDP_CLOCK_50       (clk),
    .IDP_RESET_InHigh   (rst),
    .IDP_Flush_In       (flush),
    .IDP_Lsu_Done_In    (done),
    .IDP_Lsu_Timeout_Out(tmo),
    .idp                (bus)
  );

  typedef struct packed {
    logic       nbj;
    logic       wr;
    logic       bru;
    logic       imm;
    logic       lsu;
    logic       ill;
    logic       md;
    logic [1:0] mux;
    logic [1:0] alu;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
  } exp_t;

  // Decode table written out opcode by opcode.
  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t e = '0;
    e.rd  = ins[11:7];
    e.f3  = ins[14:12];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    case (ins[6:0])
      7'h37: begin e.mux = 2'b00; e.wr = 1; e.alu = 2'b11; e.imm = 1; end
      7'h17: begin e.mux = 2'b10; e.wr = 1; e.alu = 2'b11; e.imm = 1; end
      7'h6F, 7'h67: begin e.nbj = 1; e.mux = 2'b11; e.wr = 1; e.alu = 2'b10; e.imm = 1; end
      7'h63: e.bru = 1;
      7'h03: begin e.mux = 2'b01; e.wr = 1; e.alu = 2'b01; e.imm = 1; e.lsu = 1; end
      7'h23: begin e.mux = 2'b01; e.wr = 0; e.alu = 2'b01; e.imm = 1; e.lsu = 1; end
      7'h13: begin e.wr = 1; e.imm = 1; end
      7'h33: begin
        if (ins[31:25] == 7'b0000001) begin
`ifdef IDP_MULDIV_EN
          e.wr = 1; e.md = 1;
`else
          e.ill = 1;
`endif
        end else begin
          e.wr = 1;
        end
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.nbj = bus.IDP_Not_Branch_Jump_Op;
    o.wr  = bus.IDP_RegFile_Write;
    o.bru = bus.IDP_Bru_En;
    o.imm = bus.IDP_Alu_Select_Immediate_Mux;
    o.lsu = bus.IDP_Lsu_En;
    o.ill = bus.IDP_Illegal_Out;
`ifdef IDP_MULDIV_EN
    o.md  = bus.IDP_MulDiv_En;
`else
    o.md  = 1'b0;
`endif
    o.mux = bus.IDP_RegFile_Mux_OutBUS;
    o.alu = bus.IDP_AluOp_OutBUS;
    o.rd  = bus.IDP_Rd_OutBUS;
    o.rs1 = bus.IDP_Rs1_OutBUS;
    o.rs2 = bus.IDP_Rs2_OutBUS;
    o.f3  = bus.IDP_Funct3_OutBUS;
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6F;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h13;
      6, 7: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: r[31:25] = 7'h01;
        endcase
      end
      8: r[6:0] = 7'h7F;
      default: if (r[6:0] == 7'h03 || r[6:0] == 7'h23) r[6:0] = 7'h7B;
    endcase
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsAddi;
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready_in_reset got %b want 0", bus.IDP_Instr_Ready_Out);
    end
    next_cycle();
    rst = 1'b0;
    bus.IDP_Instr_Valid_In = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0", bus.IDP_Ctrl_Valid_Out);
    end
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", bus.IDP_Instr_Ready_Out);
    end
    n_cmp++;
    if (observe() !== exp_t'(0) || tmo !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs got %h tmo %b want 0", observe(), tmo);
    end
    next_cycle();
  endtask

  task automatic test_stream();
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsAddi;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b1) begin
      n_bad++; $display("FAIL stream_ready0 got %b want 1", bus.IDP_Instr_Ready_Out);
    end
    next_cycle();
    bus.IDP_Instr_InBUS = InsAdd;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b1 || bus.IDP_Ctrl_Valid_Out !== 1'b1) begin
      n_bad++; $display("FAIL stream_ready1 got rdy %b vld %b want 1 1",
                        bus.IDP_Instr_Ready_Out, bus.IDP_Ctrl_Valid_Out);
    end
    n_cmp++;
    if (observe() !== model_decode(InsAddi) || bus.IDP_Rd_OutBUS !== 5'd1 ||
        bus.IDP_Alu_Select_Immediate_Mux !== 1'b1) begin
      n_bad++; $display("FAIL stream_addi got %h want %h", observe(), model_decode(InsAddi));
    end
    next_cycle();
    bus.IDP_Instr_Valid_In = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b1 || observe() !== model_decode(InsAdd) ||
        bus.IDP_Rd_OutBUS !== 5'd3 || bus.IDP_Alu_Select_Immediate_Mux !== 1'b0) begin
      n_bad++; $display("FAIL stream_add got %h want %h", observe(), model_decode(InsAdd));
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b0) begin
      n_bad++; $display("FAIL stream_drain got %b want 0", bus.IDP_Ctrl_Valid_Out);
    end
    next_cycle();
  endtask

  // Issue an LSU op, transfer it, then walk the wait; -1 disables done/flush.
  task automatic test_lsu_wait(input logic [31:0] ins, input int done_at, input int flush_at);
    int ended = T - 1;
    int pulses = 0;
    logic exp_tmo;
    if (done_at >= 0 && done_at < ended) ended = done_at;
    if (flush_at >= 0 && flush_at < ended) ended = flush_at;
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = ins;
    next_cycle();
    bus.IDP_Instr_Valid_In = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b1 || observe() !== model_decode(ins)) begin
      n_bad++; $display("FAIL lsu_bundle got %h want %h", observe(), model_decode(ins));
    end
    next_cycle();
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsAddi;
    for (int k = 0; k <= ended + 1; k++) begin
      done  = (k == done_at);
      flush = (k == flush_at);
      exp_tmo = (k == T - 1) && (k != done_at) && (k != flush_at);
      @(negedge clk);
      pulses += (tmo === 1'b1) ? 1 : 0;
      n_cmp++;
      if (k <= ended) begin
        if (bus.IDP_Instr_Ready_Out !== 1'b0 || tmo !== exp_tmo) begin
          n_bad++; $display("FAIL lsu_wait k=%0d got rdy %b tmo %b want 0 %b",
                            k, bus.IDP_Instr_Ready_Out, tmo, exp_tmo);
        end
      end else begin
        if (bus.IDP_Instr_Ready_Out !== 1'b1 || tmo !== 1'b0 ||
            bus.IDP_Ctrl_Valid_Out !== 1'b0) begin
          n_bad++; $display("FAIL lsu_exit k=%0d got rdy %b tmo %b vld %b want 1 0 0",
                            k, bus.IDP_Instr_Ready_Out, tmo, bus.IDP_Ctrl_Valid_Out);
        end
      end
      if (k <= ended) next_cycle();
    end
    bus.IDP_Instr_Valid_In = 1'b0;
    done  = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (pulses != ((ended == T - 1 && done_at != T - 1 && flush_at != T - 1) ? 1 : 0)) begin
      n_bad++; $display("FAIL lsu_pulse_count got %0d done_at %0d flush_at %0d",
                        pulses, done_at, flush_at);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsLw;
    next_cycle();
    bus.IDP_Instr_Valid_In = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b1 || bus.IDP_Ctrl_Valid_Out !== 1'b0 ||
        observe() !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_mid_wait got rdy %b vld %b out %h want 1 0 0",
                        bus.IDP_Instr_Ready_Out, bus.IDP_Ctrl_Valid_Out, observe());
    end
    next_cycle();
  endtask

  task automatic test_stall();
    exp_t e = model_decode(InsJal);
    bus.IDP_Ctrl_Ready_In  = 1'b0;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsJal;
    next_cycle();
    bus.IDP_Instr_InBUS = InsAdd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.IDP_Ctrl_Valid_Out !== 1'b1 || bus.IDP_Instr_Ready_Out !== 1'b0 ||
          observe() !== e || bus.IDP_Not_Branch_Jump_Op !== 1'b1 ||
          bus.IDP_RegFile_Mux_OutBUS !== 2'b11 || bus.IDP_AluOp_OutBUS !== 2'b10) begin
        n_bad++; $display("FAIL stall_hold c=%0d got vld %b rdy %b %h want 1 0 %h", c,
                          bus.IDP_Ctrl_Valid_Out, bus.IDP_Instr_Ready_Out, observe(), e);
      end
      next_cycle();
    end
    bus.IDP_Instr_Valid_In = 1'b0;
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b1 || observe() !== e) begin
      n_bad++; $display("FAIL stall_release got %h want %h", observe(), e);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Ctrl_Valid_Out !== 1'b0) begin
      n_bad++; $display("FAIL stall_single got %b want 0", bus.IDP_Ctrl_Valid_Out);
    end
    next_cycle();
  endtask

  task automatic test_flush_accept();
    bus.IDP_Ctrl_Ready_In  = 1'b0;
    bus.IDP_Instr_Valid_In = 1'b1;
    bus.IDP_Instr_InBUS    = InsAddi;
    next_cycle();
    flush = 1'b1;
    bus.IDP_Instr_InBUS = InsAdd;
    bus.IDP_Ctrl_Ready_In = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.IDP_Instr_Ready_Out !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready got %b want 0", bus.IDP_Instr_Ready_Out);
    end
    next_cycle();
    flush = 1'b0;
    bus.IDP_Instr_Valid_In = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.IDP_Ctrl_Valid_Out !== 1'b0 || bus.IDP_Instr_Ready_Out !== 1'b1 ||
          observe() !== exp_t'(0)) begin
        n_bad++; $display("FAIL flush_clear c=%0d got vld %b rdy %b out %h want 0 1 0", c,
                          bus.IDP_Ctrl_Valid_Out, bus.IDP_Instr_Ready_Out, observe());
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] list [3];
    logic        exp_ill;
    list[0] = InsBad;
    list[1] = InsMul;
    list[2] = InsLow;
    bus.IDP_Ctrl_Ready_In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IDP_Instr_Valid_In = 1'b1;
      bus.IDP_Instr_InBUS    = list[i];
      next_cycle();
      bus.IDP_Instr_Valid_In = 1'b0;
      exp_ill = 1'b1;
`ifdef IDP_MULDIV_EN
      if (i == 1) exp_ill = 1'b0;
`endif
      @(negedge clk);
      n_cmp++;
      if (observe() !== model_decode(list[i]) || bus.IDP_Illegal_Out !== exp_ill) begin
        n_bad++; $display("FAIL illegal_%0d got %h ill %b want %h ill %b", i, observe(),
                          bus.IDP_Illegal_Out, model_decode(list[i]), exp_ill);
      end
`ifdef IDP_MULDIV_EN
      n_cmp++;
      if (bus.IDP_MulDiv_En !== (i == 1)) begin
        n_bad++; $display("FAIL muldiv_%0d got %b", i, bus.IDP_MulDiv_En);
      end
`endif
      next_cycle();
    end
  endtask

  // In-order scoreboard: accepted instructions must emerge decoded, one per transfer.
  task automatic test_random(input int ncyc);
    logic [31:0] q [$];
    logic        vin, cr, fl, exp_rdy;
    for (int c = 0; c < ncyc; c++) begin
      vin = ($urandom_range(0, 3) != 0);
      cr  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      bus.IDP_Instr_Valid_In = vin;
      bus.IDP_Instr_InBUS    = rand_instr();
      bus.IDP_Ctrl_Ready_In  = cr;
      flush = fl;
      done  = ($urandom_range(0, 7) == 0);
      exp_rdy = !fl && (q.size() == 0 || cr);
      @(negedge clk);
      n_cmp++;
      if (bus.IDP_Instr_Ready_Out !== exp_rdy || tmo !== 1'b0) begin
        n_bad++; $display("FAIL rand_ready c=%0d got %b tmo %b want %b 0",
                          c, bus.IDP_Instr_Ready_Out, tmo, exp_rdy);
      end
      n_cmp++;
      if (bus.IDP_Ctrl_Valid_Out !== (q.size() != 0)) begin
        n_bad++; $display("FAIL rand_valid c=%0d got %b want %b",
                          c, bus.IDP_Ctrl_Valid_Out, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (observe() !== model_decode(q[0])) begin
          n_bad++; $display("FAIL rand_bundle c=%0d ins %h got %h want %h",
                            c, q[0], observe(), model_decode(q[0]));
        end
      end
      next_cycle();
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() != 0 && cr) void'(q.pop_front());
        if (vin && exp_rdy) q.push_back(bus.IDP_Instr_InBUS);
      end
    end
    flush = 1'b0;
    done  = 1'b0;
    bus.IDP_Instr_Valid_In = 1'b0;
    bus.IDP_Ctrl_Ready_In  = 1'b1;
    next_cycle();
  endtask

  initial begin
    bus.IDP_Instr_Valid_In = 1'b0;
    bus.IDP_Instr_InBUS    = '0;
    bus.IDP_Ctrl_Ready_In  = 1'b0;
    test_reset();
    test_stream();
    test_lsu_wait(InsLw, 3, -1);
    test_lsu_wait(InsSw, -1, -1);
    test_lsu_wait(InsSw, T - 1, -1);
    test_lsu_wait(InsLw, -1, 2);
    test_lsu_wait(InsSw, -1, T - 1);
    test_reset_mid_wait();
    test_stall();
    test_flush_accept();
    test_illegal();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
